wb_controller: RTL and testbench
================================

# wb_controller

Writeback sequencing controller for the RISC datapath's single register-file write port. It accepts one retiring instruction per cycle from decode/execute and drives the writeback source select (ALU result, load data, or PC link value), the register write enable and the destination register. It also owns the load handshake with data memory, stalls issue while a load is outstanding, and flags a memory timeout. It sits between the control unit and the writeback source mux / register file.

## Interface
- TIMEOUT, 16: maximum cycles spent waiting for `mem_ack` on a load (≥1).
- ZERO_REG, 1: when 1, writes to rd = 0 are suppressed (reg_write held 0).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  retiring instruction presented.
- issue_type  in  2  00 ALU, 01 LOAD, 10 LINK (jal/jalr), 11 NONE (store/branch; no write).
- issue_rd  in  5  destination register.
- issue_ready  out  1  controller can accept an issue this cycle.
- mem_req  out  1  load request to data memory; held until ack.
- mem_ack  in  1  load data valid on memory read bus this cycle.
- err_clr  in  1  clears timeout error.
- mem_to_reg  out  2  writeback source select: 00 ALU, 01 memory, 10 PC.
- reg_write  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- mem_err  out  1  load timed out; sticky until err_clr.

## Operation
- States: IDLE, WRITE, LOAD_WAIT, ERR. Reset → IDLE.
- Accept = issue_valid && issue_ready. issue_ready = 1 in IDLE and WRITE, 0 in LOAD_WAIT and ERR.
- In IDLE or WRITE, on accept:
  - ALU → WRITE, latch mem_to_reg = 00, wb_rd = issue_rd.
  - LINK → WRITE, latch mem_to_reg = 10, wb_rd = issue_rd.
  - LOAD → LOAD_WAIT, latch wb_rd = issue_rd, clear timeout counter, assert mem_req.
  - NONE → IDLE, no write.
- In IDLE or WRITE, no accept → IDLE.
- WRITE: reg_write = 1, except 0 when ZERO_REG=1 and wb_rd = 0. One cycle per accepted write. Back-to-back issues give back-to-back writes.
- LOAD_WAIT:
  - mem_req = 1.
  - mem_ack sampled high → WRITE with mem_to_reg = 01; mem_req drops next cycle.
  - Otherwise the counter increments. With no ack by the end of the TIMEOUT-th LOAD_WAIT cycle → ERR.
- ERR:
  - mem_err = 1, mem_req = 0, no writes.
  - err_clr → IDLE, and mem_err clears.
  - The pending load is discarded, not retried.
- Ignored events:
  - mem_ack outside LOAD_WAIT.
  - err_clr outside ERR.
  - issue_valid while issue_ready = 0. The issuer must hold it.
- Ack on the TIMEOUT-th cycle: ack wins, goes to WRITE, no error.
- mem_to_reg holds its last value when reg_write = 0. Reset value is 00.
- Timeout counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- All outputs except issue_ready are registered. issue_ready is combinational from state only, never from issue_valid.
- Reset values:
  - issue_ready = 1 (state is IDLE).
  - mem_req = 0, reg_write = 0, mem_to_reg = 00, wb_rd = 0, mem_err = 0, counter = 0.
- ALU/LINK latency: accept in cycle N → reg_write high in cycle N+1.
- LOAD latency:
  - Accept in cycle N → mem_req high in cycles N+1 through the ack cycle A.
  - reg_write high with select 01 in cycle A+1.
  - Fastest case: ack at N+1 → write at N+2.
- Next accept after a load is possible from cycle A+1, while the load is being written.
- Timeout: with no ack, mem_err rises in cycle N+TIMEOUT+1. mem_req falls in the same cycle.
- err_clr in cycle E → mem_err = 0 and issue_ready = 1 in cycle E+1.
- rst_n low mid-load or in ERR: all outputs go to reset values immediately (asynchronous) and the load is abandoned.

## Test plan
- Reset, then issue ALU rd=5 in cycle 1 → cycle 2: reg_write=1, mem_to_reg=00, wb_rd=5; cycle 3: reg_write=0.
- Back-to-back issues ALU rd=1, LINK rd=31, NONE rd=7 in cycles 1–3 → writes in cycle 2 (sel 00, rd 1) and cycle 3 (sel 10, rd 31); no write in cycle 4; issue_ready=1 throughout.
- LOAD rd=9 accepted cycle 1, mem_ack in cycle 4 → mem_req=1 in cycles 2–4, issue_ready=0 in cycles 2–4, write with sel 01 and rd 9 in cycle 5; ALU rd=2 issued in cycle 5 writes in cycle 6.
- TIMEOUT=4, LOAD with no ack → mem_err=1 and mem_req=0 in cycle 6; no reg_write. err_clr in cycle 8 → mem_err=0 and issue_ready=1 in cycle 9. Repeat with ack in the 4th wait cycle → no error, write occurs.
- ZERO_REG=1: ALU rd=0 → reg_write stays 0. ZERO_REG=0: same issue → reg_write=1, wb_rd=0.
- rst_n pulled low during LOAD_WAIT → mem_req and issue_ready take their reset values asynchronously; a mem_ack arriving after reset releases produces no write.

Source files
------------

// File: rtl/wb_controller.sv
// Writeback sequencing controller: drives the register-file write port, owns the
// load handshake with data memory and flags loads that never get acknowledged.
module wb_controller #(
  parameter int TIMEOUT  = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [1:0] issue_type,
  input  logic [4:0] issue_rd,
  output logic       issue_ready,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic       err_clr,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [4:0] wb_rd,
  output logic       mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  localparam logic [1:0] T_ALU  = 2'b00;
  localparam logic [1:0] T_LOAD = 2'b01;
  localparam logic [1:0] T_LINK = 2'b10;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, LOAD_WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       sel_nxt;
  logic [4:0]       rd_nxt;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Ready depends on state only so the issuer never sees a comb loop through issue_valid.
  assign issue_ready = (state == IDLE) || (state == WRITE);
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mem_to_reg;
    rd_nxt    = wb_rd;
    case (state)
      IDLE, WRITE: begin
        state_nxt = IDLE;
        if (accept) begin
          case (issue_type)
            T_ALU: begin
              state_nxt = WRITE;
              sel_nxt   = SEL_ALU;
              rd_nxt    = issue_rd;
            end
            T_LINK: begin
              state_nxt = WRITE;
              sel_nxt   = SEL_PC;
              rd_nxt    = issue_rd;
            end
            T_LOAD: begin
              state_nxt = LOAD_WAIT;
              rd_nxt    = issue_rd;
              cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      LOAD_WAIT: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          state_nxt = WRITE;
          sel_nxt   = SEL_MEM;
        end else begin
          cnt_nxt = sat_inc(cnt);
          if (cnt >= CNT_LAST) state_nxt = ERR;
        end
      end
      ERR: begin
        if (err_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= SEL_ALU;
      wb_rd      <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_req    <= (state_nxt == LOAD_WAIT);
      reg_write  <= (state_nxt == WRITE) && !(ZERO_REG && (rd_nxt == 5'd0));
      mem_to_reg <= sel_nxt;
      wb_rd      <= rd_nxt;
      mem_err    <= (state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_wb_controller.sv
// Directed table-driven bench for wb_controller with TIMEOUT=4; a second instance
// with ZERO_REG=0 shares the stimulus to cover writes to register 0.
module tb_wb_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [1:0] issue_type;
  logic [4:0] issue_rd;
  logic       mem_ack;
  logic       err_clr;

  logic       issue_ready, mem_req, reg_write, mem_err;
  logic [1:0] mem_to_reg;
  logic [4:0] wb_rd;

  logic       issue_ready1, mem_req1, reg_write1, mem_err1;
  logic [1:0] mem_to_reg1;
  logic [4:0] wb_rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_controller #(.TIMEOUT(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .mem_req(mem_req), .mem_ack(mem_ack),
    .err_clr(err_clr), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .wb_rd(wb_rd), .mem_err(mem_err)
  );

  wb_controller #(.TIMEOUT(4), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready1), .mem_req(mem_req1), .mem_ack(mem_ack),
    .err_clr(err_clr), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
    .wb_rd(wb_rd1), .mem_err(mem_err1)
  );

  typedef struct {
    logic       v;
    logic [1:0] t;
    logic [4:0] rd;
    logic       ack;
    logic       clr;
    logic       rdy;
    logic       req;
    logic       rw;
    logic       rw1;
    logic [1:0] sel;
    logic [4:0] wrd;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] t, input logic [4:0] rd,
                     input logic ack, input logic clr,
                     input logic rdy, input logic req, input logic rw, input logic rw1,
                     input logic [1:0] sel, input logic [4:0] wrd, input logic err);
    vec_t e;
    e.v = v; e.t = t; e.rd = rd; e.ack = ack; e.clr = clr;
    e.rdy = rdy; e.req = req; e.rw = rw; e.rw1 = rw1;
    e.sel = sel; e.wrd = wrd; e.err = err;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_type = 2'b00; issue_rd = 5'd0;
    mem_ack = 1'b0; err_clr = 1'b0;

    // Each row: inputs for one cycle, outputs expected in the following cycle.
    //   v  type   rd     ack   clr   rdy   req   rw    rw1   sel    wrd    err
    add(1, 2'b00, 5'd5,  0, 0,  1, 0, 1, 1, 2'b00, 5'd5,  0); // ALU rd5
    add(0, 2'b00, 5'd0,  0, 0,  1, 0, 0, 0, 2'b00, 5'd5,  0);
    add(1, 2'b00, 5'd1,  0, 0,  1, 0, 1, 1, 2'b00, 5'd1,  0); // back-to-back
    add(1, 2'b10, 5'd31, 0, 0,  1, 0, 1, 1, 2'b10, 5'd31, 0);
    add(1, 2'b11, 5'd7,  0, 0,  1, 0, 0, 0, 2'b10, 5'd31, 0);
    add(1, 2'b01, 5'd9,  0, 0,  0, 1, 0, 0, 2'b10, 5'd9,  0); // LOAD rd9
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b10, 5'd9,  0);
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b10, 5'd9,  0);
    add(0, 2'b00, 5'd0,  1, 0,  1, 0, 1, 1, 2'b01, 5'd9,  0); // ack
    add(1, 2'b00, 5'd2,  0, 0,  1, 0, 1, 1, 2'b00, 5'd2,  0); // issue during load write
    add(1, 2'b01, 5'd3,  0, 0,  0, 1, 0, 0, 2'b00, 5'd3,  0); // LOAD, never acked
    add(1, 2'b00, 5'd4,  0, 1,  0, 1, 0, 0, 2'b00, 5'd3,  0); // ignored issue/clr
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b00, 5'd3,  0);
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b00, 5'd3,  0);
    add(0, 2'b00, 5'd0,  0, 0,  0, 0, 0, 0, 2'b00, 5'd3,  1); // timeout
    add(1, 2'b00, 5'd6,  1, 0,  0, 0, 0, 0, 2'b00, 5'd3,  1); // ack/issue ignored in ERR
    add(0, 2'b00, 5'd0,  0, 0,  0, 0, 0, 0, 2'b00, 5'd3,  1);
    add(0, 2'b00, 5'd0,  0, 1,  1, 0, 0, 0, 2'b00, 5'd3,  0); // err_clr
    add(1, 2'b01, 5'd12, 0, 0,  0, 1, 0, 0, 2'b00, 5'd12, 0); // LOAD, ack in 4th wait
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b00, 5'd12, 0);
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b00, 5'd12, 0);
    add(0, 2'b00, 5'd0,  0, 0,  0, 1, 0, 0, 2'b00, 5'd12, 0);
    add(0, 2'b00, 5'd0,  1, 0,  1, 0, 1, 1, 2'b01, 5'd12, 0);
    add(1, 2'b00, 5'd0,  0, 0,  1, 0, 0, 1, 2'b00, 5'd0,  0); // ALU rd0
    add(0, 2'b00, 5'd0,  0, 0,  1, 0, 0, 0, 2'b00, 5'd0,  0);
    add(1, 2'b01, 5'd7,  0, 0,  0, 1, 0, 0, 2'b00, 5'd7,  0); // fastest load
    add(0, 2'b00, 5'd0,  1, 0,  1, 0, 1, 1, 2'b01, 5'd7,  0);
    add(0, 2'b00, 5'd0,  0, 0,  1, 0, 0, 0, 2'b01, 5'd7,  0);

    #12;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_req",   32'(mem_req),     32'd0);
    chk("rst_rw",    32'(reg_write),   32'd0);
    chk("rst_sel",   32'(mem_to_reg),  32'd0);
    chk("rst_rd",    32'(wb_rd),       32'd0);
    chk("rst_err",   32'(mem_err),     32'd0);

    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      issue_valid = tbl[i].v; issue_type = tbl[i].t; issue_rd = tbl[i].rd;
      mem_ack = tbl[i].ack; err_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("row%0d_ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_req",   i), 32'(mem_req),     32'(tbl[i].req));
      chk($sformatf("row%0d_rw",    i), 32'(reg_write),   32'(tbl[i].rw));
      chk($sformatf("row%0d_rw_nz", i), 32'(reg_write1),  32'(tbl[i].rw1));
      chk($sformatf("row%0d_sel",   i), 32'(mem_to_reg),  32'(tbl[i].sel));
      chk($sformatf("row%0d_rd",    i), 32'(wb_rd),       32'(tbl[i].wrd));
      chk($sformatf("row%0d_err",   i), 32'(mem_err),     32'(tbl[i].err));
    end

    // Asynchronous reset in the middle of a load wait.
    @(negedge clk);
    issue_valid = 1'b1; issue_type = 2'b01; issue_rd = 5'd20; mem_ack = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    chk("ar_req_before", 32'(mem_req), 32'd1);
    chk("ar_rd_before",  32'(wb_rd),   32'd20);
    @(negedge clk);
    issue_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_async",   32'(mem_req),     32'd0);
    chk("ar_ready_async", 32'(issue_ready), 32'd1);
    chk("ar_rd_async",    32'(wb_rd),       32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("ar_ack_rw",    32'(reg_write),   32'd0);
    chk("ar_ack_req",   32'(mem_req),     32'd0);
    chk("ar_ack_ready", 32'(issue_ready), 32'd1);
    @(negedge clk) mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("ar_post_rw",  32'(reg_write),  32'd0);
    chk("ar_post_sel", 32'(mem_to_reg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
